// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI LCD receive path.
package spi_rx_pkg;
  localparam int SPI_BITS  = 8;
  localparam int BIT_CNT_W = $clog2(SPI_BITS);

  typedef struct packed {
    logic                dc;
    logic [SPI_BITS-1:0] data;
  } rx_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;
endpackage

// File: rtl/spi_rx_fifo.sv
// Receive FIFO holding {dc, data} entries; a push while full is accepted only
// when a pop frees a slot on the same edge.
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  rx_entry_t push_data,
  input  logic      pop,
  output rx_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  rx_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  // Head reads as zero while empty so the outputs are clean after reset.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/spi_lcd_rx.sv
// SPI mode-0 target for LCD traffic: synchronizes the SPI pins into clk,
// assembles MSB-first bytes tagged with lcd_dc and queues them in a FIFO.
module spi_lcd_rx
  import spi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       lcd_dc,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overflow,
  output logic       frame_err,
  input  logic       clear,
  output logic       dbg_state
);
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
  logic                   sclk_s, mosi_s, cs_s, dc_s;
  logic                   sclk_prev_q, cs_prev_q;
  rx_state_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-1:0]    shift_q, shift_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;
  logic                   sample, cs_fall, shift_en, abort, push, pop;
  logic                   fifo_full, fifo_empty;
  rx_entry_t              push_entry, head;

  // All four pins share one depth so data, dc and cs stay aligned with the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      dc_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q[0] <= spi_clk;
      mosi_sync_q[0] <= spi_mosi;
      cs_sync_q[0]   <= spi_cs_n;
      dc_sync_q[0]   <= lcd_dc;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        dc_sync_q[i]   <= dc_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign dc_s    = dc_sync_q[SYNC_STAGES-1];
  assign sample  = sclk_s && !sclk_prev_q && !cs_s;
  assign cs_fall = cs_prev_q && !cs_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_s)    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_en    = (state_q == ST_SHIFT) && sample;
    abort       = (state_q == ST_SHIFT) && cs_s;
    push        = shift_en && (bit_cnt_q == BIT_CNT_W'(SPI_BITS-1));
    frame_err_d = abort && (bit_cnt_q != '0);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    if (abort) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (shift_en) begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      shift_d   = {shift_q[SPI_BITS-2:0], mosi_s};
    end
    // A drop on this edge outranks a clear request.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    else if (clear)                overflow_d = 1'b0;
    else                           overflow_d = overflow_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign push_entry = '{dc: dc_s, data: {shift_q[SPI_BITS-2:0], mosi_s}};
  assign pop        = rx_valid && rx_ready;

  spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign rx_data   = head.data;
  assign rx_dc     = head.dc;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed plus randomized checks of spi_lcd_rx against a queue-based model.
module tb_spi_lcd_rx;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, lcd_dc = 1'b0;
  logic       rx_ready = 1'b0, clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid, overflow, frame_err, dbg_state;

  int checks = 0;
  int failures = 0;
  int fe_count = 0, fe_run = 0, fe_max = 0;
  logic [8:0] exp_q[$];
  logic       ovf_model = 1'b0;

  spi_lcd_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc), .rx_data(rx_data), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overflow(overflow),
    .frame_err(frame_err), .clear(clear), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && frame_err) begin
      fe_count++;
      fe_run++;
      if (fe_run > fe_max) fe_max = fe_run;
    end else begin
      fe_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = d[i];
      tick(4);
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
  endtask

  // mode 0: plain; 1: check one-cycle latency (FIFO empty); 2: pop on the push edge
  task automatic send_byte(input logic [7:0] d, input logic dc, input int mode);
    lcd_dc = dc;
    send_bits(d, 7);
    spi_mosi = d[0];
    tick(4);
    spi_clk = 1'b1;
    if (mode == 1) begin
      tick(2);
      check("valid_before_push", rx_valid, 1'b0);
      tick(1);
      check("valid_after_push", rx_valid, 1'b1);
      check("data_after_push", rx_data, d);
      check("dc_after_push", rx_dc, dc);
      tick(1);
    end else if (mode == 2) begin
      tick(2);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
    end else begin
      tick(4);
    end
    spi_clk = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] d, input logic dc);
    if (exp_q.size() < DEPTH) exp_q.push_back({dc, d});
    else ovf_model = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, rx_valid, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, rx_valid, 1'b1);
      check({tag, "_data"}, rx_data, e[7:0]);
      check({tag, "_dc"}, rx_dc, e[8]);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_check(tag);
    check({tag, "_drained"}, rx_valid, 1'b0);
  endtask

  initial begin
    int fe_before;
    logic [7:0] d;
    logic       dc;
    int nb, np;

    tick(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_dc", rx_dc, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    reset_n = 1'b1;
    tick(3);

    // Single byte with latency check
    cs_low();
    check("state_shift", dbg_state, 1'b1);
    send_byte(8'hA5, 1'b1, 1);
    model_push(8'hA5, 1'b1);
    cs_high();
    check("state_idle", dbg_state, 1'b0);
    drain("a5");

    // Command then two data bytes in one frame
    fe_before = fe_count;
    cs_low();
    send_byte(8'h2C, 1'b0, 0); model_push(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1, 0); model_push(8'h12, 1'b1);
    send_byte(8'h34, 1'b1, 0); model_push(8'h34, 1'b1);
    cs_high();
    check("multi_no_ferr", fe_count, fe_before);
    drain("multi");

    // Overflow with five bytes into four slots, then clear
    cs_low();
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, 0);
      model_push(8'(i), 1'b1);
    end
    cs_high();
    check("ovf_set", overflow, ovf_model);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    ovf_model = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    drain("ovf");

    // Pop on the same edge as the push into a full FIFO
    cs_low();
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i), 1'b1, 0);
      model_push(8'(i), 1'b1);
    end
    check("full_head", rx_data, 8'h01);
    send_byte(8'h05, 1'b1, 2);
    void'(exp_q.pop_front());
    model_push(8'h05, 1'b1);
    cs_high();
    check("simul_no_ovf", overflow, 1'b0);
    drain("simul");

    // Mid-byte deassert then a clean byte
    fe_before = fe_count;
    cs_low();
    send_bits(8'hF0, 5);
    cs_high();
    check("ferr_once", fe_count, fe_before + 1);
    check("ferr_width", fe_max, 1);
    check("ferr_no_push", rx_valid, 1'b0);
    cs_low();
    send_byte(8'h3C, 1'b0, 0); model_push(8'h3C, 1'b0);
    cs_high();
    check("ferr_recover_no_ferr", fe_count, fe_before + 1);
    drain("recover");

    // Reset mid-frame
    fe_before = fe_count;
    cs_low();
    send_bits(8'hAA, 4);
    reset_n = 1'b0;
    tick(2);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_frame_err", frame_err, 1'b0);
    spi_cs_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    check("midrst_no_ferr", fe_count, fe_before);
    check("midrst_overflow", overflow, 1'b0);
    cs_low();
    send_byte(8'hFF, 1'b1, 0); model_push(8'hFF, 1'b1);
    cs_high();
    check("midrst_no_ferr2", fe_count, fe_before);
    drain("after_rst");

    // Randomized frames with random draining
    for (int it = 0; it < 20; it++) begin
      fe_before = fe_count;
      nb = $urandom_range(1, 3);
      cs_low();
      for (int b = 0; b < nb; b++) begin
        d  = 8'($urandom_range(0, 255));
        dc = 1'($urandom_range(0, 1));
        send_byte(d, dc, 0);
        model_push(d, dc);
      end
      cs_high();
      check("rnd_no_ferr", fe_count, fe_before);
      np = $urandom_range(0, exp_q.size());
      for (int p = 0; p < np; p++) pop_check("rnd");
      if (it % 5 == 4) begin
        check("rnd_ovf", overflow, ovf_model);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        ovf_model = 1'b0;
      end
    end
    drain("rnd_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_lcd_rx.md
SPI_LCD_RX -- requirements
Module: spi_lcd_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per SPI input.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_clk  input  1  SPI serial clock from the initiator; mode 0; at most clk/4.
REQ-006 spi_mosi  input  1  SPI serial data, MSB first.
REQ-007 spi_cs_n  input  1  active-low chip select; frame delimiter.
REQ-008 lcd_dc  input  1  data/command flag; 1 = data, 0 = command.
REQ-009 rx_data  output  8  head-of-FIFO byte.
REQ-010 rx_dc  output  1  lcd_dc captured with the head byte.
REQ-011 rx_valid  output  1  FIFO non-empty.
REQ-012 rx_ready  input  1  consumer accepts the head entry when rx_valid && rx_ready.
REQ-013 overflow  output  1  sticky: byte dropped because the FIFO was full.
REQ-014 frame_err  output  1  one-cycle pulse: cs_n deasserted mid-byte.
REQ-015 clear  input  1  synchronous clear of overflow.

Function
REQ-016 spi_clk, spi_mosi, spi_cs_n and lcd_dc shall each pass through SYNC_STAGES flops before use; all four share the same depth so they stay aligned.
REQ-017 A sample event is the cycle where synced spi_clk = 1 and its previous value = 0 while synced spi_cs_n = 0.
REQ-018 FSM states: IDLE (cs_n high; bit_cnt = 0), SHIFT (cs_n low). IDLE->SHIFT on synced cs_n falling; SHIFT->IDLE on synced cs_n rising.
REQ-019 In SHIFT, each sample event shall shift synced mosi into the LSB of shift_reg and increment 3-bit bit_cnt (wraps 7->0).
REQ-020 On the sample event with bit_cnt = 7, {synced lcd_dc, completed byte} shall be pushed into the FIFO on the next clk edge; rx_valid rises that same edge if the FIFO was empty (one-cycle latency from the eighth sample event).
REQ-021 Multiple bytes per frame are allowed; bit_cnt continues across bytes without cs_n toggling.
REQ-022 SHIFT->IDLE with bit_cnt != 0 shall discard partial bits, pulse frame_err for exactly one cycle and reset bit_cnt to 0.
REQ-023 Pop on rx_valid && rx_ready; rx_data/rx_dc update to the next entry on the same edge.
REQ-024 Push when full with no pop in the same cycle: byte dropped, overflow set. Push and pop in the same cycle when full: both occur, no overflow.
REQ-025 Push and pop in the same cycle when empty is impossible (rx_valid = 0); the byte is stored.
REQ-026 clear deasserts overflow next cycle; an overflow event in the same cycle wins (overflow stays 1).
REQ-027 spi_clk edges while cs_n is high shall be ignored.

Reset
REQ-028 reset_n low shall asynchronously force: FSM IDLE, bit_cnt 0, shift_reg 0, FIFO empty, rx_valid 0, rx_data 0, rx_dc 0, overflow 0, frame_err 0, synchronizers to idle values (spi_clk 0, cs_n 1, mosi 0, dc 0).
REQ-029 Reset mid-frame shall discard the partial byte without a frame_err pulse; after release, reception starts only from a fresh synced cs_n falling edge.

Structure
REQ-030 Shared package spi_rx_pkg shall hold typedef rx_entry_t {dc, data[7:0]} and constant SPI_BITS = 8.
REQ-031 The FIFO shall be a sub-module spi_rx_fifo (parameterized depth, rx_entry_t payload, full/empty, same clk/reset_n).

Verification
REQ-032 cs_n low, shift 0xA5 with dc=1, cs_n high -> one entry rx_data=0xA5, rx_dc=1, rx_valid one cycle after the eighth sample event.
REQ-033 One frame: 0x2C (dc=0) then 0x12, 0x34 (dc=1), rx_ready held 0 -> three entries in order with dc 0,1,1; no frame_err.
REQ-034 rx_ready = 0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> FIFO holds 0x01..0x04, overflow=1; clear -> overflow=0 next cycle.
REQ-035 FIFO full; pop in the same cycle as the 5th byte push -> no overflow, contents 0x02..0x05.
REQ-036 cs_n rises after 5 bits -> frame_err one-cycle pulse, no FIFO push; next full byte 0x3C received correctly.
REQ-037 reset_n pulsed low after 4 bits -> all outputs 0, no frame_err; next frame 0xFF received as 0xFF.
